// File: rtl/vector_sweep_checker_pkg.sv
// Shared types and constants for the vector sweep checker.
package vector_sweep_pkg;

    // Sweep controller states; encodings are fixed so debug tooling can decode them.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Default DUT input width; the sweep covers 2**VEC_W vectors.
    localparam int DEFAULT_VEC_W  = 4;

    // Default number of cycles each vector is held before it is sampled.
    localparam int DEFAULT_SETTLE = 2;

    // Settle counter width; wide enough for the legal settle range 1..15.
    localparam int SETTLE_CNT_W   = 4;

endpackage

// File: rtl/vector_sweep_checker_settle_timer.sv
// Settle timer: a load/enable counter that flags the last settle cycle.
module settle_timer
    import vector_sweep_pkg::*;
#(
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [SETTLE_CNT_W-1:0] TC_VAL = SETTLE_CNT_W'(SETTLE - 1);

    logic [SETTLE_CNT_W-1:0] cnt_q;
    logic [SETTLE_CNT_W-1:0] cnt_d;

    // Next count: load has priority over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is reached on the final settle cycle of a vector.
    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/vector_sweep_checker.sv
// Vector sweep checker: drives every input vector onto a small combinational
// DUT, waits a settle time, samples the response and compares it against a
// truth table latched at start. Reports error count, first failing vector and
// pass/fail.
//
// Handshake: start_i is a single-cycle request with no ready/backpressure. It is
// accepted only when the controller is idle (busy_o low and not in the done
// cycle); a request at any other time is dropped, not queued. Reset wins over a
// coincident start.
module vector_sweep_checker
    import vector_sweep_pkg::*;
#(
    parameter int VEC_W  = DEFAULT_VEC_W,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [(1<<VEC_W)-1:0]  exp_table_i,
    output logic [VEC_W-1:0]       dut_in_o,
    input  logic                   dut_out_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [VEC_W:0]         err_count_o,
    output logic [VEC_W-1:0]       first_err_vec_o,
    output logic                   first_err_valid_o,
    output state_t                 dbg_state_o
);

    localparam int N = 1 << VEC_W;
    // Index is one bit wider than the vector so the last-vector compare never wraps.
    localparam logic [VEC_W:0] IDX_LAST = (VEC_W + 1)'(N - 1);
    localparam logic [VEC_W:0] IDX_ONE  = (VEC_W + 1)'(1);

    // Reject settle values the timer cannot represent or that make no sense.
    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("vector_sweep_checker: SETTLE must be in 1..15");
        end
    endgenerate

    state_t             state_q;
    logic [N-1:0]       exp_q;
    logic [VEC_W:0]     idx_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [VEC_W:0]     err_count_q;
    logic [VEC_W-1:0]   first_err_vec_q;
    logic               first_err_valid_q;

    logic               accept_d;
    logic               last_vec_d;
    logic               mismatch_d;
    logic [VEC_W:0]     err_count_d;
    logic               timer_load_d;
    logic               timer_en_d;
    logic               settle_tc;

    // Decode of the current cycle: start acceptance, compare result, timer control.
    always_comb begin
        accept_d     = (state_q == ST_IDLE) && start_i;
        last_vec_d   = (idx_q == IDX_LAST);
        mismatch_d   = (state_q == ST_SAMPLE) && (dut_out_i != exp_q[idx_q[VEC_W-1:0]]);
        err_count_d  = err_count_q + {{VEC_W{1'b0}}, mismatch_d};
        timer_load_d = accept_d || ((state_q == ST_SAMPLE) && !last_vec_d);
        timer_en_d   = (state_q == ST_SETTLE);
    end

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (timer_load_d),
        .en_i   (timer_en_d),
        .tc_o   (settle_tc)
    );

    // Sweep controller with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_IDLE;
            exp_q             <= '0;
            idx_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        exp_q             <= exp_table_i;
                        idx_q             <= '0;
                        busy_q            <= 1'b1;
                        pass_q            <= 1'b0;
                        err_count_q       <= '0;
                        first_err_vec_q   <= '0;
                        first_err_valid_q <= 1'b0;
                        state_q           <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_tc) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_count_q <= err_count_d;
                    if (mismatch_d && !first_err_valid_q) begin
                        first_err_vec_q   <= idx_q[VEC_W-1:0];
                        first_err_valid_q <= 1'b1;
                    end
                    if (last_vec_d) begin
                        // Pass is resolved here so it is valid alongside the done pulse.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_count_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The DUT vector is the low bits of the index, so it only moves when the index does.
    assign dut_in_o          = idx_q[VEC_W-1:0];
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_count_q;
    assign first_err_vec_o   = first_err_vec_q;
    assign first_err_valid_o = first_err_valid_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Testbench for vector_sweep_checker driving a 4-input parity circuit.
module tb_vector_sweep_checker;
    import vector_sweep_pkg::*;

    localparam int VEC_W    = 4;
    localparam int SETTLE   = 2;
    localparam int N        = 1 << VEC_W;
    // Edges from the accepting edge to the edge that enters DONE.
    localparam int DONE_LAT = N * (SETTLE + 1);
    localparam int RES_W    = 1 + 1 + VEC_W + VEC_W + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     exp_table;
    logic [VEC_W-1:0] dut_in;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [VEC_W:0]   err_count;
    logic [VEC_W-1:0] first_err_vec;
    logic             first_err_valid;
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected {pass, first_err_valid, first_err_vec, err_count} per accepted sweep.
    logic [RES_W-1:0] exp_q[$];

    // Circuit under exercise: 4-input odd parity.
    assign dut_out = ^dut_in;

    vector_sweep_checker #(
        .VEC_W  (VEC_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .exp_table_i       (exp_table),
        .dut_in_o          (dut_in),
        .dut_out_i         (dut_out),
        .busy_o            (busy),
        .done_o            (done),
        .pass_o            (pass),
        .err_count_o       (err_count),
        .first_err_vec_o   (first_err_vec),
        .first_err_valid_o (first_err_valid),
        .dbg_state_o       (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference result of sweeping a table against the parity circuit.
    function automatic logic [RES_W-1:0] model_result(input logic [N-1:0] tbl);
        logic [VEC_W:0]   e;
        logic             v;
        logic [VEC_W-1:0] f;
        logic [VEC_W-1:0] vec;
        e = '0;
        v = 1'b0;
        f = '0;
        for (int i = 0; i < N; i++) begin
            vec = VEC_W'(i);
            if ((^vec) != tbl[i]) begin
                e = e + 1'b1;
                if (!v) begin
                    v = 1'b1;
                    f = vec;
                end
            end
        end
        return {(e == '0), v, f, e};
    endfunction

    // Driver: pulse start for one edge (called at a negedge), scrambling the
    // table afterwards so only the latched copy can matter.
    task automatic drive_start(input logic [N-1:0] tbl, input bit accepted);
        start     = 1'b1;
        exp_table = tbl;
        if (accepted) exp_q.push_back(model_result(tbl));
        @(negedge clk);
        start     = 1'b0;
        exp_table = N'($urandom);
        if (accepted) begin
            checks++;
            if (busy !== 1'b1 || pass !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0)
                $display("FAIL accept_clear: busy=%b pass=%b err=%0d fev=%b expected busy=1 pass=0 err=0 fev=0",
                         busy, pass, err_count, first_err_valid);
            if (busy !== 1'b1 || pass !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0) errors++;
        end
    endtask

    // Scoreboard: wait (bounded) for done, check its timing, pop and compare.
    task automatic score_done(input string name, input int lat0);
        int lat;
        logic [RES_W-1:0] exp;
        logic [RES_W-1:0] act;
        lat = lat0;
        while (done !== 1'b1 && lat < DONE_LAT + 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (done !== 1'b1 || lat != DONE_LAT) begin
            errors++;
            $display("FAIL %s_latency: done=%b after %0d edges, expected done=1 after %0d", name, done, lat, DONE_LAT);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_in_done: busy=%b expected 0", name, busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: no expected result queued", name);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
            act = {pass, first_err_valid, first_err_vec, err_count};
            if (act !== exp) begin
                errors++;
                $display("FAIL %s_result: pass=%b fev=%b fvec=%0d err=%0d expected pass=%b fev=%b fvec=%0d err=%0d",
                         name, act[RES_W-1], act[RES_W-2], act[2*VEC_W:VEC_W+1], act[VEC_W:0],
                         exp[RES_W-1], exp[RES_W-2], exp[2*VEC_W:VEC_W+1], exp[VEC_W:0]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== exp[RES_W-1] || dut_in !== VEC_W'(N - 1)) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b pass=%b dut_in=%0d expected done=0 busy=0 pass=%b dut_in=%0d",
                     name, done, busy, pass, dut_in, exp[RES_W-1], N - 1);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b1;
        exp_table = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== '0 || dut_in !== '0 ||
            first_err_vec !== '0 || first_err_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b pass=%b err=%0d dut_in=%0d fvec=%0d fev=%b state=%0d expected all 0",
                     busy, done, pass, err_count, dut_in, first_err_vec, first_err_valid, dbg_state);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: state=%0d busy=%b expected state=0 busy=0", dbg_state, busy);
        end
    endtask

    task automatic test_fixed_tables();
        drive_start(16'h6996, 1'b1);
        score_done("parity_pass", 0);
        drive_start(16'h6997, 1'b1);
        score_done("one_error", 0);
        drive_start(16'h0000, 1'b1);
        score_done("all_zero", 0);
    endtask

    task automatic test_random_tables();
        for (int t = 0; t < 3; t++) begin
            drive_start(N'($urandom_range(0, (1 << N) - 1)), 1'b1);
            score_done("random", 0);
        end
    endtask

    // Each vector is held SETTLE+1 cycles; a start during the sweep is dropped.
    task automatic test_timing_ignore_start();
        logic [VEC_W-1:0] exp_vec;
        drive_start(16'h6996, 1'b1);
        for (int c = 0; c < DONE_LAT; c++) begin
            exp_vec = VEC_W'(c / (SETTLE + 1));
            checks++;
            if (dut_in !== exp_vec || done !== 1'b0) begin
                errors++;
                $display("FAIL stim_timing: cycle %0d dut_in=%0d done=%b expected dut_in=%0d done=0", c, dut_in, done, exp_vec);
            end
            if (c == 9) begin
                start     = 1'b1;
                exp_table = 16'h0000;
            end
            if (c == 10) start = 1'b0;
            @(negedge clk);
        end
        score_done("ignored_start", DONE_LAT);
    endtask

    // Reset mid-sweep aborts with no done pulse; a fresh sweep then runs normally.
    task automatic test_mid_reset();
        int seen_done;
        seen_done = 0;
        drive_start(16'h6996, 1'b1);
        for (int c = 0; c < 19; c++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== '0 || dut_in !== '0 ||
            first_err_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_values: busy=%b done=%b pass=%b err=%0d dut_in=%0d fev=%b state=%0d expected all 0",
                     busy, done, pass, err_count, dut_in, first_err_valid, dbg_state);
        end
        for (int c = 20; c < 24; c++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midreset_no_done: done seen %0d times expected 0", seen_done);
        end
        drive_start(16'h6996, 1'b1);
        score_done("after_reset", 0);
    endtask

    // Start in the idle cycle right after done is accepted and clears old status.
    task automatic test_back_to_back();
        drive_start(16'h0000, 1'b1);
        score_done("b2b_first", 0);
        drive_start(16'h6996, 1'b1);
        score_done("b2b_second", 0);
        drive_start(16'h6997, 1'b1);
        score_done("b2b_third", 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        exp_table = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fixed_tables();
        test_timing_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random_tables();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_queue: %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
